// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StCleanup
   } uart_state_e;

   localparam int unsigned DATA_BITS = 8;

   // Bits needed to hold values 0..n-1; never narrower than 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: wraps at terminal count, flags mid-bit.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_tc,
   output logic o_half
);

   localparam int unsigned CW = clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] TC_VAL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_VAL = CW'((CLKS_PER_BIT - 1) / 2);

   logic [CW-1:0] r_cnt;

   assign o_tc = (r_cnt == TC_VAL);
   assign o_half = (r_cnt == HALF_VAL);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr || o_tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_axis_xcvr.sv
// Full-duplex 8N1 UART with an AXI-Stream master on RX and slave on TX.
module uart_axis_xcvr
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rxd,
   output logic       o_m_axis_tvalid,
   output logic [7:0] o_m_axis_tdata,
   output logic       o_s_axis_tready,
   input  logic       i_s_axis_tvalid,
   input  logic [7:0] i_s_axis_tdata,
   output logic       o_txd,
   output logic       o_txd_busy,
   output logic       o_txd_done
);

   localparam int unsigned IW = clog2(DATA_BITS);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   // ---------------- RX path ----------------
   logic                 r_rxd_meta, r_rxd_sync;
   uart_state_e          r_rx_state, w_rx_state_d;
   logic                 w_rx_clr, w_rx_tc, w_rx_half, w_rx_shift, w_rx_load;
   logic [IW-1:0]        r_rx_idx;
   logic [DATA_BITS-1:0] r_rx_shreg;
   logic                 r_m_tvalid;
   logic [7:0]           r_m_tdata;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_timer (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_rx_clr),
      .o_tc  (w_rx_tc),
      .o_half(w_rx_half)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rxd_meta <= 1'b1;
         r_rxd_sync <= 1'b1;
         r_rx_state <= StIdle;
      end else begin
         r_rxd_meta <= i_rxd;
         r_rxd_sync <= r_rxd_meta;
         r_rx_state <= w_rx_state_d;
      end
   end

   always_comb begin
      w_rx_state_d = r_rx_state;
      w_rx_clr     = 1'b0;
      w_rx_shift   = 1'b0;
      w_rx_load    = 1'b0;
      unique case (r_rx_state)
         StIdle: begin
            w_rx_clr = 1'b1;
            if (!r_rxd_sync) w_rx_state_d = StStart;
         end
         StStart: begin
            // A line that is high again at mid-bit was a glitch.
            if (w_rx_half) begin
               w_rx_clr     = 1'b1;
               w_rx_state_d = r_rxd_sync ? StIdle : StData;
            end
         end
         StData: begin
            if (w_rx_tc) begin
               w_rx_shift = 1'b1;
               if (r_rx_idx == LAST_BIT) w_rx_state_d = StStop;
            end
         end
         StStop: begin
            if (w_rx_tc) begin
               w_rx_load    = r_rxd_sync;
               w_rx_state_d = StCleanup;
            end
         end
         StCleanup: w_rx_state_d = StIdle;
         default:   w_rx_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_idx   <= '0;
         r_rx_shreg <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tdata  <= '0;
      end else begin
         r_m_tvalid <= w_rx_load;
         if (r_rx_state == StIdle) begin
            r_rx_idx <= '0;
         end else if (w_rx_shift) begin
            r_rx_idx   <= r_rx_idx + 1'b1;
            r_rx_shreg <= {r_rxd_sync, r_rx_shreg[DATA_BITS-1:1]};
         end
         if (w_rx_load) r_m_tdata <= r_rx_shreg;
      end
   end

   assign o_m_axis_tvalid = r_m_tvalid;
   assign o_m_axis_tdata  = r_m_tdata;

   // ---------------- TX path ----------------
   uart_state_e          r_tx_state, w_tx_state_d;
   logic                 r_tx_armed;
   logic [DATA_BITS-1:0] r_tx_data;
   logic [IW-1:0]        r_tx_idx;
   logic                 w_tx_clr, w_tx_tc, w_tx_half_unused, w_tx_accept;
   logic                 w_txd, w_busy, w_done;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_timer (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_tx_clr),
      .o_tc  (w_tx_tc),
      .o_half(w_tx_half_unused)
   );

   // r_tx_armed holds tready low until the first edge after reset release.
   assign o_s_axis_tready = r_tx_armed && (r_tx_state == StIdle);
   assign w_tx_accept     = i_s_axis_tvalid && o_s_axis_tready;

   always_comb begin
      w_tx_state_d = r_tx_state;
      w_tx_clr     = 1'b0;
      w_txd        = 1'b1;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      unique case (r_tx_state)
         StIdle: begin
            w_tx_clr = 1'b1;
            if (w_tx_accept) w_tx_state_d = StStart;
         end
         StStart: begin
            w_txd  = 1'b0;
            w_busy = 1'b1;
            if (w_tx_tc) w_tx_state_d = StData;
         end
         StData: begin
            w_txd  = r_tx_data[r_tx_idx];
            w_busy = 1'b1;
            if (w_tx_tc && (r_tx_idx == LAST_BIT)) w_tx_state_d = StStop;
         end
         StStop: begin
            w_busy = 1'b1;
            if (w_tx_tc) w_tx_state_d = StCleanup;
         end
         StCleanup: begin
            w_done       = 1'b1;
            w_tx_state_d = StIdle;
         end
         default: w_tx_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_state <= StIdle;
         r_tx_armed <= 1'b0;
         r_tx_data  <= '0;
         r_tx_idx   <= '0;
      end else begin
         r_tx_state <= w_tx_state_d;
         r_tx_armed <= 1'b1;
         if (w_tx_accept) r_tx_data <= i_s_axis_tdata;
         if (r_tx_state == StIdle) begin
            r_tx_idx <= '0;
         end else if ((r_tx_state == StData) && w_tx_tc) begin
            r_tx_idx <= r_tx_idx + 1'b1;
         end
      end
   end

   assign o_txd      = w_txd;
   assign o_txd_busy = w_busy;
   assign o_txd_done = w_done;

endmodule

// File: tb/tb_uart_axis_xcvr.sv
// Self-checking bench: instance A is the device under test, instance B decodes A's o_txd.
`timescale 1ns/1ps
module tb_uart_axis_xcvr;

   localparam int C = 87;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tb_rxd = 1'b1;
   logic       loop = 1'b0;
   logic       tb_tvalid = 1'b0;
   logic [7:0] tb_tdata = 8'h00;

   logic       a_m_tvalid, a_tready, a_txd, a_busy, a_done, a_s_tvalid;
   logic [7:0] a_m_tdata, a_s_tdata;
   logic       b_m_tvalid, b_tready, b_txd, b_busy, b_done;
   logic [7:0] b_m_tdata;

   always #50 clk = ~clk;

   // Loopback routes A's RX master straight into A's TX slave.
   assign a_s_tvalid = loop ? a_m_tvalid : tb_tvalid;
   assign a_s_tdata  = loop ? a_m_tdata : tb_tdata;

   uart_axis_xcvr #(.CLKS_PER_BIT(C)) u_dut_a (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_rxd          (tb_rxd),
      .o_m_axis_tvalid(a_m_tvalid),
      .o_m_axis_tdata (a_m_tdata),
      .o_s_axis_tready(a_tready),
      .i_s_axis_tvalid(a_s_tvalid),
      .i_s_axis_tdata (a_s_tdata),
      .o_txd          (a_txd),
      .o_txd_busy     (a_busy),
      .o_txd_done     (a_done)
   );

   uart_axis_xcvr #(.CLKS_PER_BIT(C)) u_dut_b (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_rxd          (a_txd),
      .o_m_axis_tvalid(b_m_tvalid),
      .o_m_axis_tdata (b_m_tdata),
      .o_s_axis_tready(b_tready),
      .i_s_axis_tvalid(1'b0),
      .i_s_axis_tdata (8'h00),
      .o_txd          (b_txd),
      .o_txd_busy     (b_busy),
      .o_txd_done     (b_done)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int idle_bad = 0;
   int busy_run = 0;
   int last_busy = 0;
   int a_done_cnt = 0;
   int b_done_cnt = 0;
   int last_rx_cyc = 0;
   logic [7:0] last_good = 8'h00;
   logic [7:0] rxa_q[$];
   logic [7:0] rxb_q[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         stretch;
      int         exp_n;
   } rx_vec_t;

   rx_vec_t rv[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_m_tvalid) begin
         rxa_q.push_back(a_m_tdata);
         last_rx_cyc <= cyc;
      end
      if (b_m_tvalid) rxb_q.push_back(b_m_tdata);
      if (a_busy) begin
         busy_run <= busy_run + 1;
      end else if (busy_run != 0) begin
         last_busy <= busy_run;
         busy_run  <= 0;
      end
      if (a_done) a_done_cnt <= a_done_cnt + 1;
      if (b_done) b_done_cnt <= b_done_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one 8N1 frame; start bit length is C+stretch cycles.
   task automatic rx_send(input logic [7:0] b, input logic stop, input int stretch,
                          output int t_start);
      t_start = cyc;
      tb_rxd = 1'b0;
      repeat (C + stretch) step();
      for (int i = 0; i < 8; i++) begin
         tb_rxd = b[i];
         repeat (C) step();
      end
      tb_rxd = stop;
      repeat (C) step();
      tb_rxd = 1'b1;
   endtask

   task automatic rx_check(input rx_vec_t v);
      int t0;
      rxa_q.delete();
      rx_send(v.data, v.stop, v.stretch, t0);
      repeat (2 * C) step();
      chk("rx_count", rxa_q.size(), v.exp_n);
      if (v.exp_n == 1 && rxa_q.size() == 1) begin
         chk("rx_data", rxa_q[0], v.data);
         chk_rng("rx_latency", last_rx_cyc - t0, 9 * C + C / 2 - 5, 9 * C + C / 2 + 10);
         last_good = v.data;
      end
      chk("rx_hold", a_m_tdata, last_good);
   endtask

   task automatic tx_handshake(output bit ok);
      bit rdy;
      ok = 1'b0;
      for (int t = 0; t < 4 * C && !ok; t++) begin
         rdy = a_tready;
         if (rdy && a_txd !== 1'b1) idle_bad++;
         step();
         if (rdy) ok = 1'b1;
      end
   endtask

   // Sends one byte and checks the whole frame cycle by cycle against 8N1 timing.
   task automatic tx_frame(input logic [7:0] b, input bit hold);
      bit ok;
      logic [9:0] frame;
      logic [7:0] dec;
      int bad_wave, bad_busy, bad_done, bad_rdy, k;
      frame = {1'b1, b, 1'b0};
      dec = 8'h00;
      bad_wave = 0; bad_busy = 0; bad_done = 0; bad_rdy = 0;
      rxb_q.delete();
      tb_tdata  = b;
      tb_tvalid = 1'b1;
      tx_handshake(ok);
      chk("tx_accept", ok, 1);
      if (!ok) begin
         tb_tvalid = 1'b0;
         return;
      end
      if (!hold) tb_tvalid = 1'b0;
      for (int c = 1; c <= 10 * C + 1; c++) begin
         if (c > 1) step();
         k = (c - 1) / C;
         if (a_txd !== ((c <= 10 * C) ? frame[k] : 1'b1)) bad_wave++;
         if (a_busy !== (c <= 10 * C)) bad_busy++;
         if (a_done !== (c == 10 * C + 1)) bad_done++;
         if (a_tready !== 1'b0) bad_rdy++;
         if (k >= 1 && k <= 8 && ((c - 1) % C) == C / 2) dec[k-1] = a_txd;
      end
      chk("tx_wave", bad_wave, 0);
      chk("tx_busy", bad_busy, 0);
      chk("tx_done", bad_done, 0);
      chk("tx_rdy_low", bad_rdy, 0);
      chk("tx_decode", dec, b);
      step();
      chk("tx_rdy_back", a_tready, 1);
      chk("tx_peer_count", rxb_q.size(), 1);
      if (rxb_q.size() == 1) chk("tx_peer_data", rxb_q[0], b);
   endtask

   initial begin
      bit ok;
      int t0, d0;
      rx_vec_t v;
      logic [7:0] rb;

      repeat (3) @(negedge clk);
      chk("rst_tvalid", a_m_tvalid, 0);
      chk("rst_tdata", a_m_tdata, 0);
      chk("rst_txd", a_txd, 1);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_tready", a_tready, 0);
      @(negedge clk) rst = 1'b0;
      #1 chk("rdy_before_edge", a_tready, 0);
      step();
      chk("rdy_after_edge", a_tready, 1);
      repeat (5) step();

      // RX vectors: fixed cases then randomized ones, expectations from the 8N1 rule.
      rv.push_back('{8'h55, 1'b1, 10, 1});
      rv.push_back('{8'h3C, 1'b1, 0, 1});
      rv.push_back('{8'h81, 1'b0, 0, 0});
      rv.push_back('{8'h7E, 1'b1, 0, 1});
      rv.push_back('{8'h00, 1'b1, -8, 1});
      rv.push_back('{8'hFF, 1'b1, 5, 1});
      for (int i = 0; i < 12; i++) begin
         v.data    = 8'($urandom_range(0, 255));
         v.stop    = ($urandom_range(0, 4) != 0);
         v.stretch = int'($urandom_range(0, 20)) - 10;
         v.exp_n   = v.stop ? 1 : 0;
         rv.push_back(v);
      end
      foreach (rv[i]) rx_check(rv[i]);

      // Glitch: 20 low cycles must be rejected, then a real frame still decodes.
      rxa_q.delete();
      tb_rxd = 1'b0;
      repeat (20) step();
      tb_rxd = 1'b1;
      repeat (2 * C) step();
      chk("glitch_none", rxa_q.size(), 0);
      rx_check('{8'h3C, 1'b1, 0, 1});

      // TX back-to-back with tvalid held, then random bytes.
      tx_frame(8'hA3, 1'b1);
      tx_frame(8'h0F, 1'b0);
      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom_range(0, 255));
         tx_frame(rb, 1'($urandom_range(0, 1)));
      end
      tb_tvalid = 1'b0;
      repeat (5) step();

      // External loopback: A's RX byte is re-sent on A's TX and decoded by B.
      rxb_q.delete();
      d0 = a_done_cnt;
      loop = 1'b1;
      rx_send(8'h55, 1'b1, 0, t0);
      repeat (11 * C) step();
      loop = 1'b0;
      chk("loop_count", rxb_q.size(), 1);
      if (rxb_q.size() == 1) chk("loop_data", rxb_q[0], 8'h55);
      chk("loop_busy_len", last_busy, 10 * C);
      chk("loop_done_pulses", a_done_cnt - d0, 1);

      // Reset during data bit 3 of 0xA5 (bit 3 is 0, so the line is low when reset hits).
      tb_tdata  = 8'hA5;
      tb_tvalid = 1'b1;
      tx_handshake(ok);
      tb_tvalid = 1'b0;
      chk("rstmid_accept", ok, 1);
      repeat (4 * C + C / 2 - 1) step();
      chk("rstmid_pre_txd", a_txd, 0);
      chk("rstmid_pre_busy", a_busy, 1);
      @(negedge clk) rst = 1'b1;
      #1;
      chk("rstmid_txd", a_txd, 1);
      chk("rstmid_busy", a_busy, 0);
      chk("rstmid_tready", a_tready, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("rstmid_rdy_low", a_tready, 0);
      step();
      chk("rstmid_rdy_high", a_tready, 1);
      tx_frame(8'h12, 1'b0);

      repeat (5) step();
      chk("idle_high", idle_bad, 0);
      chk("peer_txd_idle", b_txd, 1);
      chk("peer_tready", b_tready, 1);
      chk("peer_busy", b_busy, 0);
      chk("peer_done_none", b_done_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
